// File: rtl/seq_detect_pkg.sv
// Shared defaults for the serial pattern detector.
//   N_DEF       : pattern length in bits
//   PAT_RST_DEF : pattern loaded at reset (bit N-1 is received first)
//   CNT_W_DEF   : width of the saturating match counter
package seq_detect_pkg;
  localparam int          N_DEF       = 4;
  localparam logic [3:0]  PAT_RST_DEF = 4'b1011;
  localparam int          CNT_W_DEF   = 8;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears count
//   inc   : add one unless already at all-ones
//   count : registered count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (inc && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign count = cnt_q;
endmodule

// File: rtl/seq_detect_param.sv
// Serial N-bit pattern detector with loadable pattern, overlap control
// and a saturating detection counter.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in        : serial data bit, sampled when in_valid=1
//   in_valid  : qualifies in
//   pat_load  : load pat_in as the pattern (wins over in_valid)
//   pat_in    : new pattern, bit N-1 is the first-received bit
//   overlap   : 1 = overlapping matches, 0 = non-overlapping
//   out       : registered one-cycle detect pulse
//   match_cnt : saturating count of detections
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int           N       = N_DEF,
  parameter logic [N-1:0] PAT_RST = N'(PAT_RST_DEF),
  parameter int           CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);
  localparam int           FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  pat_q, hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_inc;
  logic          out_q;
  logic          match;

  // History and fill as they would be after accepting the current bit.
  assign hist_d   = {hist_q[N-2:0], in};
  assign fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
  assign match    = in_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_d == pat_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else if (pat_load) begin
      // Any bit offered with the load is dropped; detection restarts clean.
      pat_q  <= pat_in;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else if (in_valid) begin
      hist_q <= hist_d;
      // Non-overlap mode demands N fresh bits after every detection.
      fill_q <= (match && !overlap) ? '0 : fill_inc;
      out_q  <= match;
    end else begin
      out_q  <= 1'b0;
    end
  end

  assign out = out_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (match),
    .count(match_cnt)
  );
endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d_in = 1'b0;
  logic       in_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       overlap = 1'b1;
  logic       d_out, s_out;
  logic [7:0] cnt;
  logic [1:0] s_cnt;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .in(d_in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .out(d_out), .match_cnt(cnt)
  );

  // Narrow-counter instance for the saturation scenario; shares all stimulus.
  seq_detect_param #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in(d_in), .in_valid(in_valid), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .out(s_out), .match_cnt(s_cnt)
  );

  task automatic drive(input logic v, input logic b);
    in_valid = v;
    d_in     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; pat_load = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; d_in = 1'b1; pat_load = 1'b1; pat_in = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    vectors++; if (d_out !== 1'b0) begin $display("FAIL reset_out got %b want 0", d_out); errs++; end
    vectors++; if (cnt !== 8'd0) begin $display("FAIL reset_cnt got %0d want 0", cnt); errs++; end
    vectors++; if (s_cnt !== 2'd0) begin $display("FAIL reset_scnt got %0d want 0", s_cnt); errs++; end
    // Reset pattern must be 1011, not the pat_in offered during reset.
    drive(1, 1); drive(1, 0); drive(1, 1); drive(1, 1);
    vectors++; if (d_out !== 1'b1) begin $display("FAIL reset_pat got %b want 1", d_out); errs++; end
  endtask

  task automatic test_overlap();
    logic [6:0] stim = 7'b1011011;
    logic [6:0] exp  = 7'b0001001;
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1, stim[6-i]);
      vectors++;
      if (d_out !== exp[6-i]) begin $display("FAIL overlap_bit%0d got %b want %b", i+1, d_out, exp[6-i]); errs++; end
    end
    vectors++; if (cnt !== 8'd2) begin $display("FAIL overlap_cnt got %0d want 2", cnt); errs++; end
  endtask

  task automatic test_non_overlap();
    logic [6:0] stim = 7'b1011011;
    logic [6:0] exp  = 7'b0001000;
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1, stim[6-i]);
      vectors++;
      if (d_out !== exp[6-i]) begin $display("FAIL nonovl_bit%0d got %b want %b", i+1, d_out, exp[6-i]); errs++; end
    end
    vectors++; if (cnt !== 8'd1) begin $display("FAIL nonovl_cnt got %0d want 1", cnt); errs++; end
    overlap = 1'b1;
  endtask

  task automatic test_valid_gaps();
    logic [3:0] stim = 4'b1011;
    logic [3:0] exp  = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, stim[3-i]);
      vectors++;
      if (d_out !== exp[3-i]) begin $display("FAIL gaps_bit%0d got %b want %b", i+1, d_out, exp[3-i]); errs++; end
      // Idle cycles carry the opposite data value, which must be ignored.
      drive(0, ~stim[3-i]);
      drive(0, ~stim[3-i]);
      vectors++;
      if (d_out !== 1'b0) begin $display("FAIL gaps_idle%0d got %b want 0", i+1, d_out); errs++; end
    end
    vectors++; if (cnt !== 8'd1) begin $display("FAIL gaps_cnt got %0d want 1", cnt); errs++; end
  endtask

  task automatic test_pat_load();
    logic [3:0] s1 = 4'b0110;
    logic [3:0] s2 = 4'b1011;
    logic [3:0] e1 = 4'b0001;
    do_reset();
    overlap = 1'b0;
    // Pre-fill the history so a match would occur if fill were not cleared.
    drive(1, 0); drive(1, 1); drive(1, 1);
    pat_load = 1'b1; pat_in = 4'b0110;
    drive(1, 0);
    pat_load = 1'b0;
    vectors++; if (d_out !== 1'b0) begin $display("FAIL load_out got %b want 0", d_out); errs++; end
    for (int i = 0; i < 4; i++) begin
      drive(1, s1[3-i]);
      vectors++;
      if (d_out !== e1[3-i]) begin $display("FAIL load_new_bit%0d got %b want %b", i+1, d_out, e1[3-i]); errs++; end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, s2[3-i]);
      vectors++;
      if (d_out !== 1'b0) begin $display("FAIL load_old_bit%0d got %b want 0", i+1, d_out); errs++; end
    end
    vectors++; if (cnt !== 8'd1) begin $display("FAIL load_cnt got %0d want 1", cnt); errs++; end
    pat_load = 1'b1; pat_in = 4'b1011;
    drive(0, 0);
    pat_load = 1'b0;
    vectors++; if (cnt !== 8'd1) begin $display("FAIL load_cnt_hold got %0d want 1", cnt); errs++; end
    overlap = 1'b1;
  endtask

  task automatic test_saturation();
    logic [6:0]  exp = 7'b0001111;
    logic [1:0]  ec [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    overlap = 1'b1;
    pat_load = 1'b1; pat_in = 4'b1111;
    drive(0, 0);
    pat_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(1, 1);
      vectors++;
      if (s_out !== exp[6-i]) begin $display("FAIL sat_out_bit%0d got %b want %b", i+1, s_out, exp[6-i]); errs++; end
      vectors++;
      if (s_cnt !== ec[i]) begin $display("FAIL sat_cnt_bit%0d got %0d want %0d", i+1, s_cnt, ec[i]); errs++; end
    end
    vectors++; if (cnt !== 8'd4) begin $display("FAIL sat_wide_cnt got %0d want 4", cnt); errs++; end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp = 4'b0001;
    do_reset();
    overlap = 1'b1;
    drive(1, 1); drive(1, 0); drive(1, 1);
    rst = 1'b1;
    drive(1, 1);
    rst = 1'b0;
    vectors++; if (d_out !== 1'b0) begin $display("FAIL rmid_rst_out got %b want 0", d_out); errs++; end
    // Fill should now be 1 after the next bit: three more bits complete 1011.
    drive(1, 1);
    vectors++; if (d_out !== 1'b0) begin $display("FAIL rmid_first_out got %b want 0", d_out); errs++; end
    vectors++; if (cnt !== 8'd0) begin $display("FAIL rmid_cnt got %0d want 0", cnt); errs++; end
    drive(1, 0);
    vectors++; if (d_out !== exp[2]) begin $display("FAIL rmid_bit2 got %b want %b", d_out, exp[2]); errs++; end
    drive(1, 1);
    vectors++; if (d_out !== exp[1]) begin $display("FAIL rmid_bit3 got %b want %b", d_out, exp[1]); errs++; end
    drive(1, 1);
    vectors++; if (d_out !== exp[0]) begin $display("FAIL rmid_bit4 got %b want %b", d_out, exp[0]); errs++; end
    vectors++; if (cnt !== 8'd1) begin $display("FAIL rmid_cnt_end got %0d want 1", cnt); errs++; end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_pat_load();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter N, default 4: pattern length in bits, legal range 2..32.
REQ-002 SHALL have parameter PAT_RST, default 4'b1011 (N bits): pattern value after reset.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in, input, 1 bit: serial data bit.
REQ-007 SHALL have port in_valid, input, 1 bit: in is sampled only when in_valid=1.
REQ-008 SHALL have port pat_load, input, 1 bit: load pat_in as the new pattern.
REQ-009 SHALL have port pat_in, input, N bits: new pattern; bit N-1 is the oldest (first-received) bit.
REQ-010 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-011 SHALL have port out, output, 1 bit: registered Moore detect flag.
REQ-012 SHALL have port match_cnt, output, CNT_W bits: saturating count of detections.

Function
REQ-013 SHALL keep an N-bit history shift register; on each valid bit: hist <= {hist[N-2:0], in}.
REQ-014 SHALL keep a fill count (0..N) of valid bits accepted since the last clear; it increments on each valid bit and saturates at N.
REQ-015 SHALL declare a match on a valid bit when, after the shift, fill = N and hist equals the pattern register.
REQ-016 SHALL set out=1 in exactly the cycle following the clock edge that accepted the completing bit (one-cycle latency), and out=0 in all other cycles.
REQ-017 SHALL, with overlap=1, leave fill at N after a match, so the next valid bit can complete another match.
REQ-018 SHALL, with overlap=0, clear fill to 0 on a match, so N fresh valid bits are required before the next match.
REQ-019 SHALL sample overlap at the edge that accepts the matching bit; a mode change between matches takes effect at the next match.
REQ-020 SHALL leave hist, fill and out unchanged when in_valid=0, except that out SHALL clear to 0.
REQ-021 SHALL, on pat_load=1, load pat_in into the pattern register, clear fill to 0 and clear out to 0 at the same edge.
REQ-022 SHALL discard any valid bit presented in a pat_load cycle; pat_load has priority over in_valid.
REQ-023 SHALL leave match_cnt unchanged on pat_load.
REQ-024 SHALL increment match_cnt by 1 on each match and hold it at 2^CNT_W-1 once saturated.
REQ-025 SHALL update match_cnt in the same edge that sets out=1.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set pattern=PAT_RST, hist=0, fill=0, out=0 and match_cnt=0.
REQ-027 SHALL give rst priority over pat_load and in_valid; a partial match in progress at reset is lost.
REQ-028 SHALL register every output, so outputs carry no combinational path from any input.

Structure
REQ-029 SHALL take default constants (N, PAT_RST, CNT_W defaults) from shared package seq_detect_pkg.
REQ-030 SHALL implement the saturating match counter as sub-module sat_counter (parameter W; ports clk, rst, inc, count).
REQ-031 SHALL be 120-400 lines of RTL in total, with no memories and no multi-cycle paths.

Verification
REQ-032 SHALL cover overlap: defaults, overlap=1, valid stream 1,0,1,1,0,1,1 -> out=1 after bits 4 and 7, match_cnt=2.
REQ-033 SHALL cover non-overlap: same stream, overlap=0 -> out=1 after bit 4 only, match_cnt=1.
REQ-034 SHALL cover valid gaps: stream 1,0,1,1 with in_valid=0 idle cycles between bits -> single out pulse one cycle after bit 4, idle bits ignored, match_cnt=1.
REQ-035 SHALL cover pattern load: pat_load with pat_in=4'b0110 and in_valid=1, in=0 in the same cycle -> that bit discarded; then valid stream 0,1,1,0 -> out=1 once, and 1,0,1,1 -> no match.
REQ-036 SHALL cover saturation: CNT_W=2, overlap=1, stream 1,1,1,1,1,1,1 with pattern 4'b1111 -> matches on bits 4 through 7, match_cnt reaches 3 and holds 3.
REQ-037 SHALL cover reset mid-match: stream 1,0,1, then rst for one cycle, then 1 -> no match, fill=1, out=0, match_cnt=0.
